// File: rtl/downcounter_bank.sv
// Bank of independent down-counters with load, one-shot/auto-reload, and a registered done pulse on 1->0; Q/done one cycle after the edge, no backpressure.
// Define COUNTER_PRESCALE_EN to advance counters only on a shared tick every PRESCALE clocks (otherwise they advance every clock).
module downcounter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] limit,
  input  logic [CHANNELS-1:0]       reload,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       done
);

  logic tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick  = (pre_q == PW'(PRESCALE - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end
`else
  logic prescale_unused;
  assign prescale_unused = (PRESCALE > 0);
  assign tick = 1'b1;
`endif

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    lim_q [CHANNELS];
  logic [WIDTH-1:0]    lim_d [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      lim_d[i]  = lim_q[i];
      done_d[i] = 1'b0;
      if (load[i]) begin
        cnt_d[i] = limit[i*WIDTH +: WIDTH];
        lim_d[i] = limit[i*WIDTH +: WIDTH];
      end else if (en[i] && tick) begin
        if (cnt_q[i] == WIDTH'(1)) begin
          cnt_d[i]  = '0;
          done_d[i] = 1'b1;
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end else if (reload[i]) begin
          // A stored limit of 0 reloads 0, so the channel idles without pulsing done.
          cnt_d[i] = lim_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        lim_q[i] <= '0;
      end
      done_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        lim_q[i] <= lim_d[i];
      end
      done_q <= done_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign Q[g*WIDTH +: WIDTH] = cnt_q[g];
    assign zero[g]             = (cnt_q[g] == '0);
  end

  assign done = done_q;

endmodule

// File: tb/tb_downcounter_bank.sv
// Scoreboard bench for downcounter_bank in the default (no prescaler) build, 4 channels x 8 bits.
module tb_downcounter_bank;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   en, load, reload, zero, done;
  logic [C*W-1:0] limit, Q;

  typedef struct packed {
    logic [C*W-1:0] q;
    logic [C-1:0]   d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  downcounter_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (load),
    .limit  (limit),
    .reload (reload),
    .Q      (Q),
    .zero   (zero),
    .done   (done)
  );

  task automatic apply_reset();
    reset = 1'b1; en = '0; load = '0; reload = '0; limit = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (Q !== '0) $display("FAIL reset_q: Q=%h expected 0", Q); else n_pass++;
    n_checks++;
    if (done !== '0) $display("FAIL reset_done: done=%b expected 0", done); else n_pass++;
    n_checks++;
    if (zero !== 4'b1111) $display("FAIL reset_zero: zero=%b expected 1111", zero); else n_pass++;
    load = 4'b1111; en = 4'b1111; limit = 32'hffff_ffff;
    @(posedge clk); #1;
    n_checks++;
    if (Q !== '0) $display("FAIL reset_hold_q: Q=%h expected 0 while reset held", Q); else n_pass++;
    load = '0; en = '0; limit = '0;
  endtask

  task automatic test_load_after_reset();
    exp_t e, a;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      load  = (c == 0) ? 4'b0001 : 4'b0000;
      en    = 4'b0001;
      limit = 32'h0000_0005;
      e.q = 32'(5 - c); e.d = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL load_after_reset c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    exp_t e, a;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      load = (c == 0) ? 4'b0001 : 4'b0000;
      en = 4'b0001; reload = '0; limit = 32'h0000_0003;
      e.q = 32'((c < 3) ? 3 - c : 0);
      e.d = (c == 3) ? 4'b0001 : 4'b0000;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL oneshot c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  task automatic test_autoreload();
    exp_t e, a;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      load = (c == 0) ? 4'b0010 : 4'b0000;
      en = 4'b0010; reload = 4'b0010; limit = 32'h0000_0200;
      e.q = 32'(2 - (c % 3)) << 8;
      e.d = ((c % 3) == 2) ? 4'b0010 : 4'b0000;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL autoreload c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    exp_t e, a;
    bit ld_s[11]  = '{1,0,0,0,1,1,0,0,1,1,0};
    bit en_s[11]  = '{1,1,1,1,1,0,0,1,1,1,1};
    int lim_s[11] = '{8,0,0,0,9,7,0,0,1,4,0};
    int exp_s[11] = '{8,7,6,5,9,7,7,6,1,4,3};
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      load  = ld_s[c] ? 4'b0100 : 4'b0000;
      en    = en_s[c] ? 4'b0100 : 4'b0000;
      limit = 32'(lim_s[c]) << 16;
      e.q = 32'(exp_s[c]) << 16; e.d = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL load_priority c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  task automatic test_zero_limit();
    exp_t e, a;
    apply_reset();
    // Preload a nonzero value so the limit-0 load visibly clears it.
    load = 4'b0001; limit = 32'h0000_0009;
    @(posedge clk); #1;
    for (int c = 0; c < 11; c++) begin
      load = (c == 0) ? 4'b0001 : 4'b0000;
      en = 4'b0001; reload = 4'b0001; limit = '0;
      e.q = '0; e.d = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL zero_limit c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
    n_checks++;
    if (zero !== 4'b1111) $display("FAIL zero_limit_flag: zero=%b expected 1111", zero); else n_pass++;
  endtask

  task automatic test_reset_midcount();
    exp_t e, a;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      load = (c == 0) ? 4'b1010 : 4'b0000;
      en = 4'b1010; reload = 4'b0010; limit = 32'h0600_0200;
      e.q = (32'(6 - c) << 24) | (32'(2 - c) << 8);
      e.d = (c == 2) ? 4'b0010 : 4'b0000;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL midcount_pre c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (Q !== '0) $display("FAIL midcount_async_q: Q=%h expected 0", Q); else n_pass++;
    n_checks++;
    if (done !== '0) $display("FAIL midcount_async_done: done=%b expected 0", done); else n_pass++;
    n_checks++;
    if (zero !== 4'b1111) $display("FAIL midcount_async_zero: zero=%b expected 1111", zero); else n_pass++;
    #2 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e.q = '0; e.d = '0;
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL midcount_post c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, a;
    int   v;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      load = (c == 0) ? 4'b1111 : 4'b0000;
      en = 4'b1111; reload = '0; limit = 32'h0403_0201;
      e.q = '0; e.d = '0;
      for (int ch = 0; ch < C; ch++) begin
        v = ch + 1 - c;
        e.q[ch*W +: W] = (v > 0) ? 8'(v) : 8'd0;
        e.d[ch]        = (c == ch + 1);
      end
      sb.push_back(e);
      @(posedge clk); #1;
      a = sb.pop_front();
      n_checks++;
      if (Q !== a.q || done !== a.d)
        $display("FAIL back_to_back c%0d: Q=%h done=%b expected Q=%h done=%b", c, Q, done, a.q, a.d);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; en = '0; load = '0; reload = '0; limit = '0;
    test_reset();
    test_load_after_reset();
    test_oneshot();
    test_autoreload();
    test_load_priority();
    test_zero_limit();
    test_reset_midcount();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
